// File: rtl/decode_queue_if.sv
// Fetch-side and issue-side handshake bundle for decode_queue.
// master = fetch/issue environment, slave = the decode queue itself.
interface decode_queue_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_op;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_op_type;
  logic [6:0]      out_op_spec;
  logic [31:0]     out_imm;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [4:0]      out_rd;
  logic            out_illegal;
  logic [PC_W-1:0] out_pc;

  modport master (
    output in_valid, in_op, in_pc, out_ready,
    input  in_ready, out_valid, out_op_type, out_op_spec, out_imm,
           out_rs1, out_rs2, out_rd, out_illegal, out_pc
  );

  modport slave (
    input  in_valid, in_op, in_pc, out_ready,
    output in_ready, out_valid, out_op_type, out_op_spec, out_imm,
           out_rs1, out_rs2, out_rd, out_illegal, out_pc
  );
endinterface

// File: rtl/decode_queue.sv
// RV32I(M) decode stage: combinational decode of the incoming word, results
// buffered in a DEPTH-entry FIFO whose head drives issue directly.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter bit RV32M = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  decode_queue_if.slave              q,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [4:0] T_ARITH  = 5'b00001;
  localparam logic [4:0] T_MEM    = 5'b00010;
  localparam logic [4:0] T_BRANCH = 5'b00100;
  localparam logic [4:0] T_JUMP   = 5'b01000;
  localparam logic [4:0] T_SYSTEM = 5'b10000;

  localparam logic [5:0] S_ADD = 6'd0,  S_SUB = 6'd1,  S_SLL  = 6'd2,  S_SLT  = 6'd3;
  localparam logic [5:0] S_SLTU = 6'd4, S_XOR = 6'd5,  S_SRL  = 6'd6,  S_SRA  = 6'd7;
  localparam logic [5:0] S_OR  = 6'd8,  S_AND = 6'd9,  S_MUL  = 6'd10, S_LUI  = 6'd18;
  localparam logic [5:0] S_AUIPC = 6'd19, S_LB = 6'd20, S_LH  = 6'd21, S_LW   = 6'd22;
  localparam logic [5:0] S_LBU = 6'd23, S_LHU = 6'd24, S_SB   = 6'd25, S_SH   = 6'd26;
  localparam logic [5:0] S_SW  = 6'd27, S_BEQ = 6'd28, S_BNE  = 6'd29, S_BLT  = 6'd30;
  localparam logic [5:0] S_BGE = 6'd31, S_BLTU = 6'd32, S_BGEU = 6'd33, S_JAL = 6'd34;
  localparam logic [5:0] S_JALR = 6'd35;

  typedef struct packed {
    logic [4:0]      op_type;
    logic [6:0]      op_spec;
    logic [31:0]     imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            illegal;
    logic [PC_W-1:0] pc;
  } entry_t;

  function automatic logic [5:0] alu_code(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_code = S_ADD;
      3'b001:  alu_code = S_SLL;
      3'b010:  alu_code = S_SLT;
      3'b011:  alu_code = S_SLTU;
      3'b100:  alu_code = S_XOR;
      3'b101:  alu_code = S_SRL;
      3'b110:  alu_code = S_OR;
      default: alu_code = S_AND;
    endcase
  endfunction

  logic [6:0]        opc, f7;
  logic [2:0]        f3;
  logic signed [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign opc   = q.in_op[6:0];
  assign f3    = q.in_op[14:12];
  assign f7    = q.in_op[31:25];
  assign imm_i = {{20{q.in_op[31]}}, q.in_op[31:20]};
  assign imm_s = {{20{q.in_op[31]}}, q.in_op[31:25], q.in_op[11:7]};
  assign imm_b = {{19{q.in_op[31]}}, q.in_op[31], q.in_op[7], q.in_op[30:25], q.in_op[11:8], 1'b0};
  assign imm_j = {{11{q.in_op[31]}}, q.in_op[31], q.in_op[19:12], q.in_op[20], q.in_op[30:21], 1'b0};
  assign imm_u = {q.in_op[31:12], 12'b0};

  logic [4:0]  d_type;
  logic [5:0]  d_code;
  logic        d_immop;
  logic [31:0] d_imm;
  logic        d_ill;

  always_comb begin
    d_type  = T_SYSTEM;
    d_code  = '0;
    d_immop = 1'b0;
    d_imm   = '0;
    d_ill   = 1'b1;
    case (opc)
      7'b0110011: begin
        d_type = T_ARITH;
        if (f7 == 7'b0000000) begin
          d_ill  = 1'b0;
          d_code = alu_code(f3);
        end else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) begin
          d_ill  = 1'b0;
          d_code = (f3 == 3'b000) ? S_SUB : S_SRA;
        end else if (f7 == 7'b0000001 && RV32M) begin
          d_ill  = 1'b0;
          d_code = S_MUL + {3'b000, f3};
        end
      end
      7'b0010011: begin
        d_type  = T_ARITH;
        d_immop = 1'b1;
        d_imm   = imm_i;
        d_code  = alu_code(f3);
        case (f3)
          3'b001: d_ill = (f7 != 7'b0000000);
          3'b101: begin
            d_ill = !(f7 == 7'b0000000 || f7 == 7'b0100000);
            if (f7 == 7'b0100000) d_code = S_SRA;
          end
          default: d_ill = 1'b0;
        endcase
      end
      7'b0000011: begin
        d_type = T_MEM;
        d_imm  = imm_i;
        d_ill  = 1'b0;
        case (f3)
          3'b000:  d_code = S_LB;
          3'b001:  d_code = S_LH;
          3'b010:  d_code = S_LW;
          3'b100:  d_code = S_LBU;
          3'b101:  d_code = S_LHU;
          default: d_ill  = 1'b1;
        endcase
      end
      7'b0100011: begin
        d_type = T_MEM;
        d_imm  = imm_s;
        d_ill  = 1'b0;
        case (f3)
          3'b000:  d_code = S_SB;
          3'b001:  d_code = S_SH;
          3'b010:  d_code = S_SW;
          default: d_ill  = 1'b1;
        endcase
      end
      7'b1100011: begin
        d_type = T_BRANCH;
        d_imm  = imm_b;
        d_ill  = 1'b0;
        case (f3)
          3'b000:  d_code = S_BEQ;
          3'b001:  d_code = S_BNE;
          3'b100:  d_code = S_BLT;
          3'b101:  d_code = S_BGE;
          3'b110:  d_code = S_BLTU;
          3'b111:  d_code = S_BGEU;
          default: d_ill  = 1'b1;
        endcase
      end
      7'b1101111: begin
        d_type = T_JUMP;
        d_code = S_JAL;
        d_imm  = imm_j;
        d_ill  = 1'b0;
      end
      7'b1100111: begin
        d_type = T_JUMP;
        d_code = S_JALR;
        d_imm  = imm_i;
        d_ill  = (f3 != 3'b000);
      end
      7'b0110111, 7'b0010111: begin
        d_type  = T_ARITH;
        d_code  = (opc == 7'b0110111) ? S_LUI : S_AUIPC;
        d_immop = 1'b1;
        d_imm   = imm_u;
        d_ill   = 1'b0;
      end
      default: ;
    endcase
    // Illegal words carry only register indices and PC; issue raises the trap.
    if (d_ill) begin
      d_type  = T_SYSTEM;
      d_code  = '0;
      d_immop = 1'b0;
      d_imm   = '0;
    end
  end

  entry_t dec_entry;
  assign dec_entry = '{op_type: d_type, op_spec: {d_immop, d_code}, imm: d_imm,
                       rs1: q.in_op[19:15], rs2: q.in_op[24:20], rd: q.in_op[11:7],
                       illegal: d_ill, pc: q.in_pc};

  // ---- stage p0: queue storage and pointers ----
  entry_t          queue_p0 [DEPTH];
  logic [AW-1:0]   wptr_p0, rptr_p0;
  logic [CW-1:0]   cnt_p0;
  logic            vld_p0;
  logic            push, pop;

  assign vld_p0     = (cnt_p0 != '0);
  assign q.in_ready = (cnt_p0 < CW'(DEPTH)) && !rst;
  assign push       = q.in_valid && q.in_ready && !flush;
  assign pop        = vld_p0 && q.out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_p0 <= '0;
      rptr_p0 <= '0;
      cnt_p0  <= '0;
    end else begin
      if (push) wptr_p0 <= wptr_p0 + 1'b1;
      if (pop)  rptr_p0 <= rptr_p0 + 1'b1;
      cnt_p0 <= cnt_p0 + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) queue_p0[wptr_p0] <= dec_entry;
  end

  entry_t head;
  assign head = vld_p0 ? queue_p0[rptr_p0] : '0;

  assign count         = cnt_p0;
  assign q.out_valid   = vld_p0;
  assign q.out_op_type = head.op_type;
  assign q.out_op_spec = head.op_spec;
  assign q.out_imm     = head.imm;
  assign q.out_rs1     = head.rs1;
  assign q.out_rs2     = head.rs2;
  assign q.out_rd      = head.rd;
  assign q.out_illegal = head.illegal;
  assign q.out_pc      = head.pc;
endmodule

// File: tb/tb_decode_queue.sv
// Randomised and directed bench for decode_queue; a pattern-table ISA model and
// a queue scoreboard predict every head entry, count and in_ready.
module tb_decode_queue;
  localparam int DEPTH = 4;

  localparam logic [4:0] T_ARITH = 5'b00001, T_MEM = 5'b00010, T_BRANCH = 5'b00100;
  localparam logic [4:0] T_JUMP  = 5'b01000, T_SYSTEM = 5'b10000;

  typedef struct packed {
    logic        valid;
    logic [4:0]  typ;
    logic [6:0]  spec;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    logic [4:0]  typ;
    logic [6:0]  spec;
    int          fmt;   // 0 none, 1 I, 2 S, 3 B, 4 J, 5 U
    bit          mext;
  } pat_t;

  logic clk, rst, flush;
  logic [2:0] count0, count1;
  int checks = 0;
  int errors = 0;
  pat_t pats[$];
  exp_t mq[$];

  decode_queue_if #(.PC_W(32)) if0 ();
  decode_queue_if #(.PC_W(32)) if1 ();

  assign if1.in_valid  = if0.in_valid;
  assign if1.in_op     = if0.in_op;
  assign if1.in_pc     = if0.in_pc;
  assign if1.out_ready = if0.out_ready;

  decode_queue #(.DEPTH(DEPTH), .PC_W(32), .RV32M(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush), .q(if0), .count(count0));
  decode_queue #(.DEPTH(DEPTH), .PC_W(32), .RV32M(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush), .q(if1), .count(count1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual running, required finished");
    $fatal(1, "watchdog");
  end

  task automatic add(input logic [31:0] mask, input logic [31:0] match, input logic [4:0] typ,
                     input logic [6:0] spec, input int fmt, input bit mext);
    pat_t p;
    p.mask = mask; p.match = match; p.typ = typ; p.spec = spec; p.fmt = fmt; p.mext = mext;
    pats.push_back(p);
  endtask

  task automatic build_table();
    logic [31:0] rm;
    rm = 32'hFE00707F;
    add(rm, 32'h00000033, T_ARITH, 7'd0, 0, 0);  add(rm, 32'h40000033, T_ARITH, 7'd1, 0, 0);
    add(rm, 32'h00001033, T_ARITH, 7'd2, 0, 0);  add(rm, 32'h00002033, T_ARITH, 7'd3, 0, 0);
    add(rm, 32'h00003033, T_ARITH, 7'd4, 0, 0);  add(rm, 32'h00004033, T_ARITH, 7'd5, 0, 0);
    add(rm, 32'h00005033, T_ARITH, 7'd6, 0, 0);  add(rm, 32'h40005033, T_ARITH, 7'd7, 0, 0);
    add(rm, 32'h00006033, T_ARITH, 7'd8, 0, 0);  add(rm, 32'h00007033, T_ARITH, 7'd9, 0, 0);
    for (int k = 0; k < 8; k++) add(rm, 32'h02000033 | (k << 12), T_ARITH, 7'(10 + k), 0, 1);
    add(32'h707F, 32'h00000013, T_ARITH, 7'h40 | 7'd0, 1, 0);
    add(32'h707F, 32'h00002013, T_ARITH, 7'h40 | 7'd3, 1, 0);
    add(32'h707F, 32'h00003013, T_ARITH, 7'h40 | 7'd4, 1, 0);
    add(32'h707F, 32'h00004013, T_ARITH, 7'h40 | 7'd5, 1, 0);
    add(32'h707F, 32'h00006013, T_ARITH, 7'h40 | 7'd8, 1, 0);
    add(32'h707F, 32'h00007013, T_ARITH, 7'h40 | 7'd9, 1, 0);
    add(rm, 32'h00001013, T_ARITH, 7'h40 | 7'd2, 1, 0);
    add(rm, 32'h00005013, T_ARITH, 7'h40 | 7'd6, 1, 0);
    add(rm, 32'h40005013, T_ARITH, 7'h40 | 7'd7, 1, 0);
    add(32'h707F, 32'h00000003, T_MEM, 7'd20, 1, 0);  add(32'h707F, 32'h00001003, T_MEM, 7'd21, 1, 0);
    add(32'h707F, 32'h00002003, T_MEM, 7'd22, 1, 0);  add(32'h707F, 32'h00004003, T_MEM, 7'd23, 1, 0);
    add(32'h707F, 32'h00005003, T_MEM, 7'd24, 1, 0);
    add(32'h707F, 32'h00000023, T_MEM, 7'd25, 2, 0);  add(32'h707F, 32'h00001023, T_MEM, 7'd26, 2, 0);
    add(32'h707F, 32'h00002023, T_MEM, 7'd27, 2, 0);
    add(32'h707F, 32'h00000063, T_BRANCH, 7'd28, 3, 0); add(32'h707F, 32'h00001063, T_BRANCH, 7'd29, 3, 0);
    add(32'h707F, 32'h00004063, T_BRANCH, 7'd30, 3, 0); add(32'h707F, 32'h00005063, T_BRANCH, 7'd31, 3, 0);
    add(32'h707F, 32'h00006063, T_BRANCH, 7'd32, 3, 0); add(32'h707F, 32'h00007063, T_BRANCH, 7'd33, 3, 0);
    add(32'h7F, 32'h6F, T_JUMP, 7'd34, 4, 0);
    add(32'h707F, 32'h67, T_JUMP, 7'd35, 1, 0);
    add(32'h7F, 32'h37, T_ARITH, 7'h40 | 7'd18, 5, 0);
    add(32'h7F, 32'h17, T_ARITH, 7'h40 | 7'd19, 5, 0);
  endtask

  function automatic exp_t model_decode(input logic [31:0] op, input logic [31:0] pc, input bit m);
    exp_t e;
    e = '0;
    e.valid = 1'b1; e.typ = T_SYSTEM; e.ill = 1'b1; e.pc = pc;
    e.rs1 = op[19:15]; e.rs2 = op[24:20]; e.rd = op[11:7];
    foreach (pats[i]) begin
      if (e.ill && (op & pats[i].mask) == pats[i].match && (!pats[i].mext || m)) begin
        e.ill = 1'b0; e.typ = pats[i].typ; e.spec = pats[i].spec;
        case (pats[i].fmt)
          1: e.imm = 32'($signed(op[31:20]));
          2: e.imm = 32'($signed({op[31:25], op[11:7]}));
          3: e.imm = 32'($signed({op[31], op[7], op[30:25], op[11:8], 1'b0}));
          4: e.imm = 32'($signed({op[31], op[19:12], op[20], op[30:21], 1'b0}));
          5: e.imm = op & 32'hFFFFF000;
          default: e.imm = 32'h0;
        endcase
      end
    end
    return e;
  endfunction

  function automatic exp_t exp_head();
    return (mq.size() == 0) ? exp_t'('0) : mq[0];
  endfunction

  function automatic exp_t dut_head0();
    exp_t r;
    r = '{if0.out_valid, if0.out_op_type, if0.out_op_spec, if0.out_imm, if0.out_rs1,
          if0.out_rs2, if0.out_rd, if0.out_illegal, if0.out_pc};
    return r;
  endfunction

  function automatic logic [31:0] rand_word();
    int k;
    if ($urandom_range(0, 9) < 7) begin
      k = $urandom_range(0, pats.size() - 1);
      return ($urandom & ~pats[k].mask) | pats[k].match;
    end
    return $urandom;
  endfunction

  // Drives one cycle from a negedge, advances the scoreboard at the posedge,
  // and returns at the following negedge.
  task automatic step(input bit v, input logic [31:0] op, input logic [31:0] pc, input bit rdy,
                      input bit fl, input bit rs, output bit obs_rdy, output bit exp_rdy);
    bit acc, pp;
    if0.in_valid = v; if0.in_op = op; if0.in_pc = pc; if0.out_ready = rdy;
    flush = fl; rst = rs;
    #1;
    obs_rdy = if0.in_ready;
    exp_rdy = (mq.size() < DEPTH) && !rs;
    acc = v && exp_rdy && !fl;
    pp  = (mq.size() > 0) && rdy;
    @(posedge clk);
    if (rs || fl) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (acc) mq.push_back(model_decode(op, pc, 1'b0));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit o, e;
    step(0, 0, 0, 0, 0, 1, o, e);
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL reset_in_ready: actual %b, required 0", o); end
    step(0, 0, 0, 0, 0, 1, o, e);
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL reset_count: actual %0d, required 0", count0); end
    checks++; if (dut_head0() !== exp_t'('0)) begin errors++; $display("FAIL reset_outputs: actual %h, required 0", dut_head0()); end
    step(0, 0, 0, 0, 0, 0, o, e);
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: actual %b, required 1", o); end
  endtask

  task automatic test_decode();
    bit o, e;
    step(1, 32'hFFF10093, 32'h100, 0, 0, 0, o, e);
    checks++;
    if (if0.out_valid !== 1'b1 || if0.out_op_type !== T_ARITH || if0.out_op_spec !== 7'h40 ||
        if0.out_imm !== 32'hFFFFFFFF || if0.out_rs1 !== 5'd2 || if0.out_rd !== 5'd1 ||
        if0.out_illegal !== 1'b0 || if0.out_pc !== 32'h100) begin
      errors++; $display("FAIL addi_head: actual %h, required valid ARITH spec 40 imm ffffffff rs1 2 rd 1 pc 100", dut_head0());
    end
    step(1, 32'h123452B7, 32'h104, 0, 0, 0, o, e);
    step(1, 32'h00322423, 32'h108, 0, 0, 0, o, e);
    step(1, 32'hFE000EE3, 32'h10C, 0, 0, 0, o, e);
    checks++; if (count0 !== 3'd4) begin errors++; $display("FAIL decode_count: actual %0d, required 4", count0); end
    step(0, 0, 0, 1, 0, 0, o, e);
    checks++; if (if0.out_imm !== 32'h12345000 || if0.out_rd !== 5'd5 || if0.out_op_spec !== 7'h52) begin
      errors++; $display("FAIL lui_head: actual imm %h rd %0d spec %h, required 12345000 5 52", if0.out_imm, if0.out_rd, if0.out_op_spec); end
    step(0, 0, 0, 1, 0, 0, o, e);
    checks++; if (if0.out_imm !== 32'h8 || if0.out_rs1 !== 5'd4 || if0.out_rs2 !== 5'd3 || if0.out_op_type !== T_MEM) begin
      errors++; $display("FAIL sw_head: actual imm %h rs1 %0d rs2 %0d, required 8 4 3", if0.out_imm, if0.out_rs1, if0.out_rs2); end
    step(0, 0, 0, 1, 0, 0, o, e);
    checks++; if (if0.out_imm !== 32'hFFFFFFFC || if0.out_op_type !== T_BRANCH || if0.out_pc !== 32'h10C) begin
      errors++; $display("FAIL beq_head: actual imm %h type %b pc %h, required fffffffc 00100 10c", if0.out_imm, if0.out_op_type, if0.out_pc); end
    step(0, 0, 0, 1, 0, 0, o, e);
    checks++; if (count0 !== 3'd0 || if0.out_valid !== 1'b0) begin
      errors++; $display("FAIL decode_drain: actual count %0d valid %b, required 0 0", count0, if0.out_valid); end
  endtask

  task automatic test_full_wrap();
    bit o, e;
    step(1, rand_word(), 32'h200, 0, 0, 0, o, e);
    step(0, 0, 0, 1, 0, 0, o, e);
    for (int i = 0; i <= DEPTH; i++) step(1, rand_word(), 32'h300 + 4 * i, 0, 0, 0, o, e);
    checks++; if (o !== 1'b0 || count0 !== 3'(DEPTH)) begin
      errors++; $display("FAIL full_refuse: actual in_ready %b count %0d, required 0 %0d", o, count0, DEPTH); end
    step(1, rand_word(), 32'h3FC, 1, 0, 0, o, e);
    checks++; if (o !== 1'b0 || count0 !== 3'(DEPTH - 1)) begin
      errors++; $display("FAIL full_no_bypass: actual in_ready %b count %0d, required 0 %0d", o, count0, DEPTH - 1); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (dut_head0() !== exp_head()) begin
        errors++; $display("FAIL wrap_order: actual %h, required %h", dut_head0(), exp_head()); end
      step(0, 0, 0, 1, 0, 0, o, e);
    end
    checks++; if (count0 !== 3'd0) begin errors++; $display("FAIL wrap_drain: actual %0d, required 0", count0); end
  endtask

  task automatic test_illegal_mext();
    bit o, e;
    step(1, 32'h00000000, 32'h400, 0, 0, 0, o, e);
    step(1, 32'h023100B3, 32'h404, 0, 0, 0, o, e);
    checks++; if (if0.out_illegal !== 1'b1 || if1.out_illegal !== 1'b1 || if0.out_op_type !== T_SYSTEM) begin
      errors++; $display("FAIL zero_word_illegal: actual %b/%b, required 1/1", if0.out_illegal, if1.out_illegal); end
    step(0, 0, 0, 1, 0, 0, o, e);
    checks++; if (if0.out_illegal !== 1'b1 || dut_head0() !== exp_head()) begin
      errors++; $display("FAIL mul_rv32i: actual %h, required %h", dut_head0(), exp_head()); end
    checks++; if (if1.out_illegal !== 1'b0 || if1.out_op_type !== T_ARITH || if1.out_op_spec !== 7'd10 || if1.out_rd !== 5'd1) begin
      errors++; $display("FAIL mul_rv32m: actual ill %b type %b spec %h, required 0 00001 0a", if1.out_illegal, if1.out_op_type, if1.out_op_spec); end
    step(0, 0, 0, 1, 0, 0, o, e);
  endtask

  task automatic test_flush_rst();
    bit o, e;
    for (int i = 0; i < 3; i++) step(1, rand_word(), 32'h500 + 4 * i, 0, 0, 0, o, e);
    checks++; if (count0 !== 3'd3) begin errors++; $display("FAIL flush_fill: actual %0d, required 3", count0); end
    step(1, 32'hFFF10093, 32'h50C, 0, 1, 0, o, e);
    checks++; if (count0 !== 3'd0 || dut_head0() !== exp_t'('0)) begin
      errors++; $display("FAIL flush_clear: actual count %0d head %h, required 0 0", count0, dut_head0()); end
    step(0, 0, 0, 0, 0, 0, o, e);
    checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop: actual %b, required 0", if0.out_valid); end
    for (int i = 0; i < 2; i++) step(1, rand_word(), 32'h600 + 4 * i, 0, 0, 0, o, e);
    step(1, rand_word(), 32'h608, 0, 0, 1, o, e);
    checks++; if (o !== 1'b0 || count0 !== 3'd0 || if0.out_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid: actual in_ready %b count %0d valid %b, required 0 0 0", o, count0, if0.out_valid); end
    step(1, rand_word(), 32'h700, 0, 0, 0, o, e);
    step(1, rand_word(), 32'h704, 0, 1, 1, o, e);
    checks++; if (o !== 1'b0 || count0 !== 3'd0) begin
      errors++; $display("FAIL flush_rst: actual in_ready %b count %0d, required 0 0", o, count0); end
    step(0, 0, 0, 0, 0, 0, o, e);
  endtask

  task automatic test_random();
    bit o, e;
    logic [31:0] pc;
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, rand_word(), pc, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0, o, e);
      pc += 4;
      checks++; if (o !== e) begin errors++; $display("FAIL rand_in_ready[%0d]: actual %b, required %b", i, o, e); end
      checks++; if (count0 !== 3'(mq.size())) begin
        errors++; $display("FAIL rand_count[%0d]: actual %0d, required %0d", i, count0, mq.size()); end
      checks++; if (dut_head0() !== exp_head()) begin
        errors++; $display("FAIL rand_head[%0d]: actual %h, required %h", i, dut_head0(), exp_head()); end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    if0.in_valid = 1'b0; if0.in_op = '0; if0.in_pc = '0; if0.out_ready = 1'b0;
    build_table();
    @(negedge clk);
    test_reset();
    test_decode();
    test_full_wrap();
    test_illegal_mext();
    test_flush_rst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered RV32I(M) decode stage with a parametrised output queue.
- Sits between fetch and issue in s2_decode.
- Accepts raw instruction words with their PC over a valid/ready handshake. Fully decodes each word into type, spec, immediate, register indices and an illegal flag, then buffers the results in a DEPTH-entry FIFO toward issue.
- Supports pipeline flush. Optionally decodes the M extension.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- PC_W, 32, PC width carried alongside each instruction.
- RV32M, 0, 1 = decode MUL/DIV/REM (funct7 0000001, opcode 0110011); 0 = flag them illegal.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued entries.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept.
- in_op  in  32  raw instruction word.
- in_pc  in  PC_W  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  issue consumes head.
- out_op_type  out  5  ARITHMETIC/MEMORY/BRANCH/JUMP/SYSTEM (shared types header).
- out_op_spec  out  7  bit6 = immediate operand for ARITHMETIC; bits5:0 = operation code from the shared types header.
- out_imm  out  32  assembled, sign-extended immediate.
- out_rs1  out  5  rs1 index.
- out_rs2  out  5  rs2 index.
- out_rd  out  5  rd index.
- out_illegal  out  1  unrecognised encoding.
- out_pc  out  PC_W  PC of head entry.
- count  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - Pointers and count clear to 0; out_valid=0.
  - All out_* data fields read 0 while empty.
  - in_ready is 0 during the reset cycle.
- Push on in_valid && in_ready. Pop on out_valid && out_ready.
- in_ready = (count < DEPTH) && !rst. There is no bypass: a full queue refuses a push even if a pop occurs in the same cycle.
- Latency: a word pushed at edge N is visible at the head at N+1 if the queue was empty. Decoded fields are computed combinationally from in_op and stored; outputs come straight from storage.
- Simultaneous push and pop when 0<count<DEPTH: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- flush:
  - Clears pointers and count at the next edge; any same-cycle push is dropped.
  - out_valid=0 the following cycle.
  - flush and rst together behave as rst.
- Decode rules:
  - Every field has a default: op_type SYSTEM, op_spec 0, imm 0, illegal 1. No latches.
  - 0110011: funct7 0000000 selects add/sll/slt/sltu/xor/srl/or/and. funct7 0100000 with funct3 000/101 selects sub/sra. funct7 0000001 is legal only if RV32M. Anything else is illegal. op_spec[6]=0, imm=0.
  - 0010011: op_spec[6]=1, imm=sext(op[31:20]). For funct3 101, op[31:25]=0000000 gives SRL and 0100000 gives SRA; other values are illegal. For funct3 001, op[31:25] must be 0.
  - 0000011 loads: LB/LH/LW/LBU/LHU; funct3 011/110/111 are illegal. imm=sext(op[31:20]).
  - 0100011 stores: SB/SH/SW. imm=sext({op[31:25],op[11:7]}).
  - 1100011 branches: BEQ/BNE/BLT/BGE/BLTU/BGEU; funct3 010/011 are illegal. imm=sext({op[31],op[7],op[30:25],op[11:8],0}).
  - 1101111: JUMP, JAL. imm=sext({op[31],op[19:12],op[20],op[30:21],0}).
  - 1100111: JUMP, JALR (distinct spec from JAL). Requires funct3 000. imm=sext(op[31:20]).
  - 0110111: ARITHMETIC, LUI. 0010111: ARITHMETIC, AUIPC. For both, imm={op[31:12],12'b0} and op_spec[6]=1.
  - Any other opcode: illegal=1. An illegal entry is still queued; issue handles the trap.
- rs1/rs2/rd are always taken from op[19:15]/op[24:20]/op[11:7], regardless of format.

Test Plan:
- Reset, then push 0xFFF10093 (addi x1,x2,-1) with pc 0x100 -> next cycle out_valid=1, ARITHMETIC, op_spec[6]=1, spec ADD, imm 0xFFFFFFFF, rs1=2, rd=1, illegal=0, out_pc 0x100.
- Push 0x123452B7 (LUI x5), 0x00322423 (sw x3,8(x4)), 0xFE000EE3 (beq x0,x0,-4) -> imm values 0x12345000, 0x00000008, 0xFFFFFFFC. The sw entry has rs1=4 and rs2=3.
- out_ready=0, push DEPTH+1 words -> count=DEPTH, in_ready=0, extra word not accepted. Then pop all -> FIFO order preserved across pointer wrap, count returns to 0.
- Push 0x00000000, and 0x023100B3 (mul) with RV32M=0 -> illegal=1 for both. Rebuild with RV32M=1 -> mul has illegal=0.
- At count=3, assert flush together with in_valid -> next cycle count=0, out_valid=0, pushed word discarded. Assert rst mid-stream -> same result, with in_ready=0 during the rst cycle.
